// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I constants and fetch-stage types
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/if_fifo.sv
// if_fifo: synchronous FIFO used for the fetch response buffer and the PC tag queue
// Ports: CLK/RST (sync, active-high), push/pop/flush controls, din/dout data, count occupancy.
// Flush overrides push/pop; callers never push when full or pop when empty.
module if_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign dout = mem[rd_ptr];
endmodule

// File: rtl/if_stage.sv
// if_stage: RV32I instruction-fetch stage feeding the F/D register
// Ports: CLK/RST (sync, active-high); IMEM_* request/grant and in-order response
// interface; STALL_D, REDIRECT/REDIRECT_PC from later stages; INSTR_FD/PC_FD/PC4_FD/VALID_FD
// to decode. Define IF_BUBBLE_CNT_EN to add the FETCH_BUBBLES saturating bubble counter.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        STALL_D,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic [31:0] INSTR_FD,
    output logic [31:0] PC_FD,
    output logic [31:0] PC4_FD,
    output logic        VALID_FD
`ifdef IF_BUBBLE_CNT_EN
    ,
    output logic [31:0] FETCH_BUBBLES
`endif
);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int CW1 = CW + 1;

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, tag_pc;
    logic [CW-1:0]   outstanding, drop, fifo_count, tag_count, out_nxt, drop_nxt;
    logic            gnt_ok, rsp, rsp_acc, fd_load, fifo_pop, fifo_push, bypass, load;
    fetch_entry_t    fifo_head, rsp_entry, ld;

    assign gnt_ok    = IMEM_REQ && IMEM_GNT;
    // Responses with nothing outstanding are strays (e.g. after reset) and are ignored.
    assign rsp       = IMEM_RVALID && outstanding != '0;
    // Live tags exist only for non-stale fetches; a response racing a redirect is stale.
    assign rsp_acc   = IMEM_RVALID && drop == '0 && tag_count != '0 && !REDIRECT;
    assign fd_load   = !STALL_D && !REDIRECT;
    assign fifo_pop  = fd_load && fifo_count != '0;
    assign bypass    = fd_load && fifo_count == '0 && rsp_acc;
    assign fifo_push = rsp_acc && !bypass;
    assign load      = fifo_pop || bypass;
    assign out_nxt   = outstanding + CW'(gnt_ok) - CW'(rsp);
    // Everything still in flight after a redirect belongs to the old path.
    assign drop_nxt  = REDIRECT ? out_nxt : drop - CW'(rsp && drop != '0);
    assign rsp_entry = '{pc: tag_pc, instr: IMEM_RDATA};
    assign ld        = fifo_pop ? fifo_head : rsp_entry;
    assign IMEM_ADDR = pc;

    if_fifo #(.WIDTH(2 * XLEN), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (REDIRECT),
        .din   (rsp_entry),
        .dout  (fifo_head),
        .count (fifo_count)
    );

    if_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH), .CW(CW)) u_tag (
        .CLK   (CLK),
        .RST   (RST),
        .push  (gnt_ok),
        .pop   (rsp_acc),
        .flush (REDIRECT),
        .din   (pc),
        .dout  (tag_pc),
        .count (tag_count)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE  ? FETCH :
                    state == FETCH ? (REDIRECT && out_nxt != '0 ? DRAIN : FETCH) :
                                     (drop_nxt == '0 ? FETCH : DRAIN);
    end

    // Outstanding plus buffered never exceeds the FIFO depth, so every response has a slot.
    always_comb begin
        IMEM_REQ = state == FETCH && !REDIRECT &&
                   ({1'b0, outstanding} + {1'b0, fifo_count}) < CW1'(FIFO_DEPTH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc          <= RESET_PC & ~32'h3;
            outstanding <= '0;
            drop        <= '0;
            VALID_FD    <= 1'b0;
            INSTR_FD    <= NOP_INSTR;
            PC_FD       <= '0;
            PC4_FD      <= '0;
        end else begin
            outstanding <= out_nxt;
            drop        <= drop_nxt;
            if (REDIRECT) pc <= REDIRECT_PC & ~32'h3;
            else if (gnt_ok) pc <= pc + 32'd4;
            if (REDIRECT) VALID_FD <= 1'b0;
            else if (fd_load) VALID_FD <= load;
            if (fd_load && load) begin
                INSTR_FD <= ld.instr;
                PC_FD    <= ld.pc;
                PC4_FD   <= ld.pc + 32'd4;
            end
        end
    end

`ifdef IF_BUBBLE_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) FETCH_BUBBLES <= '0;
        else if (state != IDLE && !VALID_FD && !STALL_D && FETCH_BUBBLES != '1)
            FETCH_BUBBLES <= FETCH_BUBBLES + 32'd1;
    end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage with a one-cycle-latency memory model
module tb_if_stage;
    logic        CLK = 1'b0;
    logic        RST, IMEM_REQ, IMEM_GNT, IMEM_RVALID, STALL_D, REDIRECT, VALID_FD;
    logic [31:0] IMEM_ADDR, IMEM_RDATA, REDIRECT_PC, INSTR_FD, PC_FD, PC4_FD;
`ifdef IF_BUBBLE_CNT_EN
    logic [31:0] FETCH_BUBBLES;
`endif

    int          checks = 0;
    int          errors = 0;
    bit          rsp_en = 1'b1;
    logic [31:0] pend [$];

    always #5 CLK = ~CLK;

    if_stage #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_GNT    (IMEM_GNT),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .STALL_D     (STALL_D),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .INSTR_FD    (INSTR_FD),
        .PC_FD       (PC_FD),
        .PC4_FD      (PC4_FD),
        .VALID_FD    (VALID_FD)
`ifdef IF_BUBBLE_CNT_EN
        ,
        .FETCH_BUBBLES (FETCH_BUBBLES)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Memory returns addr ^ 0x1234_0000 one cycle after each grant while rsp_en is set.
    task automatic step();
        logic        g;
        logic [31:0] a;
        g = !RST && IMEM_REQ && IMEM_GNT;
        a = IMEM_ADDR;
        @(posedge CLK);
        #1;
        if (g) pend.push_back(a);
        if (rsp_en && pend.size() > 0) begin
            IMEM_RVALID = 1'b1;
            IMEM_RDATA  = pend.pop_front() ^ 32'h1234_0000;
        end else begin
            IMEM_RVALID = 1'b0;
            IMEM_RDATA  = '0;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = '0;
        STALL_D = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0;
        pend.delete();
        rsp_en = 1'b1;
        step();
        step();
        RST = 1'b0;
    endtask

    initial begin
        // Streaming from reset, then a 3-cycle decode stall
        do_reset();
        IMEM_GNT = 1'b1;
        @(negedge CLK);
        check("rst_req", IMEM_REQ, 0); check("rst_addr", IMEM_ADDR, 32'h100);
        check("rst_valid", VALID_FD, 0); check("rst_instr", INSTR_FD, 32'h13);
        check("rst_pc", PC_FD, 0); check("rst_pc4", PC4_FD, 0);
        step();
        @(negedge CLK); check("first_req", IMEM_REQ, 1); check("first_addr", IMEM_ADDR, 32'h100); step();
        @(negedge CLK); check("second_addr", IMEM_ADDR, 32'h104); check("pre_valid", VALID_FD, 0); step();
        @(negedge CLK);
        check("s1_valid", VALID_FD, 1); check("s1_pc0", PC_FD, 32'h100);
        check("s1_pc4_0", PC4_FD, 32'h104); check("s1_instr0", INSTR_FD, 32'h1234_0100);
        step();
        @(negedge CLK); check("s1_pc1", PC_FD, 32'h104); step();
        @(negedge CLK); check("s1_pc2", PC_FD, 32'h108); check("s1_pc4_2", PC4_FD, 32'h10c); step();
        STALL_D = 1'b1;
        @(negedge CLK); check("stall_pc_a", PC_FD, 32'h10c); check("stall_valid", VALID_FD, 1); step();
        @(negedge CLK); check("stall_req_b", IMEM_REQ, 0); check("stall_pc_b", PC_FD, 32'h10c); step();
        @(negedge CLK); check("stall_req_c", IMEM_REQ, 0); check("stall_pc_c", PC_FD, 32'h10c); step();
        STALL_D = 1'b0;
        @(negedge CLK); check("rel_req", IMEM_REQ, 0); check("rel_pc_hold", PC_FD, 32'h10c); step();
        @(negedge CLK);
        check("rel_pc0", PC_FD, 32'h110); check("rel_instr0", INSTR_FD, 32'h1234_0110);
        check("rel_req1", IMEM_REQ, 1); check("rel_addr", IMEM_ADDR, 32'h118);
        step();
        @(negedge CLK); check("rel_pc1", PC_FD, 32'h114); step();
        @(negedge CLK); check("rel_pc2", PC_FD, 32'h118); check("rel_pc4_2", PC4_FD, 32'h11c); check("rel_valid", VALID_FD, 1);

        // Redirect to a misaligned target with two fetches outstanding
        do_reset();
        IMEM_GNT = 1'b1; rsp_en = 1'b0;
        step(); step(); step();
        @(negedge CLK); check("cap_req", IMEM_REQ, 0); step();
        REDIRECT = 1'b1; REDIRECT_PC = 32'h2002;
        @(negedge CLK); check("redir_req", IMEM_REQ, 0); rsp_en = 1'b1; step();
        REDIRECT = 1'b0;
        @(negedge CLK); check("drain_req0", IMEM_REQ, 0); check("drain_valid0", VALID_FD, 0); step();
        @(negedge CLK); check("drain_req1", IMEM_REQ, 0); step();
        @(negedge CLK);
        check("tgt_req", IMEM_REQ, 1); check("tgt_addr", IMEM_ADDR, 32'h2000); check("drain_valid1", VALID_FD, 0);
        step();
        @(negedge CLK); check("tgt_valid0", VALID_FD, 0); step();
        @(negedge CLK);
        check("tgt_valid", VALID_FD, 1); check("tgt_pc", PC_FD, 32'h2000); check("tgt_instr", INSTR_FD, 32'h1234_2000);

        // Redirect beats a stall, in-flight fetch drained
        do_reset();
        IMEM_GNT = 1'b1;
        step(); step();
        rsp_en = 1'b0;
        step();
        STALL_D = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 32'h3000;
        @(negedge CLK); check("rs_valid_pre", VALID_FD, 1); check("rs_pc_pre", PC_FD, 32'h100); check("rs_req", IMEM_REQ, 0); step();
        REDIRECT = 1'b0; STALL_D = 1'b0; rsp_en = 1'b1;
        @(negedge CLK); check("rs_valid", VALID_FD, 0); check("rs_drain_req0", IMEM_REQ, 0); step();
        @(negedge CLK); check("rs_drain_req1", IMEM_REQ, 0); step();
        @(negedge CLK); check("rs_req_tgt", IMEM_REQ, 1); check("rs_addr", IMEM_ADDR, 32'h3000); check("rs_valid_post", VALID_FD, 0);

        // Ungranted request held, withdrawn by redirect, then PC wraps
        do_reset();
        step();
        @(negedge CLK); check("hold_req", IMEM_REQ, 1); check("hold_addr0", IMEM_ADDR, 32'h100); step();
        @(negedge CLK); check("hold_addr1", IMEM_ADDR, 32'h100); step();
        REDIRECT = 1'b1; REDIRECT_PC = 32'hffff_fffc;
        @(negedge CLK); check("wd_req", IMEM_REQ, 0); step();
        REDIRECT = 1'b0; IMEM_GNT = 1'b1;
        @(negedge CLK); check("wrap_req", IMEM_REQ, 1); check("wrap_addr0", IMEM_ADDR, 32'hffff_fffc); step();
        @(negedge CLK); check("wrap_addr1", IMEM_ADDR, 32'h0); step();
        @(negedge CLK);
        check("wrap_valid", VALID_FD, 1); check("wrap_pc", PC_FD, 32'hffff_fffc);
        check("wrap_pc4", PC4_FD, 32'h0); check("wrap_instr", INSTR_FD, 32'hedcb_fffc);

        // Reset with two fetches outstanding, stray responses afterwards
        do_reset();
        IMEM_GNT = 1'b1; rsp_en = 1'b0;
        step(); step(); step();
        RST = 1'b1;
        step();
        RST = 1'b0; pend.delete(); rsp_en = 1'b1;
        IMEM_RVALID = 1'b1; IMEM_RDATA = 32'hdead_beef;
        @(negedge CLK);
        check("mr_req", IMEM_REQ, 0); check("mr_addr", IMEM_ADDR, 32'h100); check("mr_valid", VALID_FD, 0);
        check("mr_instr", INSTR_FD, 32'h13); check("mr_pc", PC_FD, 0); check("mr_pc4", PC4_FD, 0);
        step();
        IMEM_RVALID = 1'b1; IMEM_RDATA = 32'hdead_beef;
        @(negedge CLK); check("mr_req1", IMEM_REQ, 1); check("mr_addr1", IMEM_ADDR, 32'h100); check("mr_valid1", VALID_FD, 0); step();
        @(negedge CLK); check("stray_valid", VALID_FD, 0); step();
        @(negedge CLK); check("mr_fd_valid", VALID_FD, 1); check("mr_fd_pc", PC_FD, 32'h100); check("mr_fd_instr", INSTR_FD, 32'h1234_0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
